// File: rtl/vga_sync_gen.sv
// Free-running VGA raster timing generator: pixel-rate enable, h/v counters and
// zero-latency sync / blanking / start-of-line / start-of-frame decode.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       p_tick,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start,
    output logic       line_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode bounds kept 32 bits wide so a sync pulse ending exactly at 1024 still compares correctly.
    localparam int unsigned H_VIS_END  = H_VISIBLE;
    localparam int unsigned HS_START   = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END     = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned V_VIS_END  = V_VISIBLE;
    localparam int unsigned VS_START   = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END     = V_VISIBLE + V_FRONT + V_SYNC;

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [31:0] h_wide;
    logic [31:0] v_wide;

    generate
        if (CLK_DIV == 1) begin : g_no_div
            assign p_tick = 1'b1;
        end else begin : g_div
            localparam int DIV_W = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

            logic [DIV_W-1:0] div_cnt;

            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of block ordering.
            always_ff @(posedge clk) begin
                if (rst) begin
                    div_cnt <= '0;
                end else if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            assign p_tick = (div_cnt == DIV_LAST);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (p_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign h_wide = {22'd0, h_cnt};
    assign v_wide = {22'd0, v_cnt};

    assign x_pos       = h_cnt;
    assign y_pos       = v_cnt;
    assign hsync       = !((h_wide >= HS_START) && (h_wide < HS_END));
    assign vsync       = !((v_wide >= VS_START) && (v_wide < VS_END));
    assign video_on    = (h_wide < H_VIS_END) && (v_wide < V_VIS_END);
    assign line_start  = p_tick && (h_cnt == 10'd0);
    assign frame_start = p_tick && (h_cnt == 10'd0) && (v_cnt == 10'd0);

endmodule
